// File: rtl/tinycomp_io_ctrl.sv
// I/O bus controller for the TinyComp CPU: internal LED / cycle / status registers
// plus a req/ack handshake with timeout for the external device window 0x00-0xFF.
module tinycomp_io_ctrl #(
   parameter int unsigned TIMEOUT  = 64,
   parameter logic [31:0] ERR_DATA = 32'hFFFF_FFFF
) (
   input  logic        clk,
   input  logic        Reset,
   input  logic [31:0] IOaddr,
   input  logic [31:0] OutData,
   input  logic        InStrobe,
   input  logic        OutStrobe,
   output logic [31:0] InData,
   output logic        InRdy,
   output logic [7:0]  leds,
   output logic        dev_req,
   output logic        dev_we,
   output logic [7:0]  dev_addr,
   output logic [31:0] dev_wdata,
   input  logic [31:0] dev_rdata,
   input  logic        dev_ack
);

   localparam logic [31:0] ADDR_LED    = 32'h0000_03FF;
   localparam logic [31:0] ADDR_CYCLE  = 32'h0000_03FE;
   localparam logic [31:0] ADDR_STATUS = 32'h0000_03FD;
   localparam logic [15:0] WAIT_LAST   = 16'(TIMEOUT - 1);

   typedef enum logic {IDLE, DEV} state_t;

   state_t      state_q, state_d;
   logic [31:0] in_data_q, in_data_d;
   logic [7:0]  leds_q, leds_d;
   logic        dev_we_q, dev_we_d;
   logic [7:0]  dev_addr_q, dev_addr_d;
   logic [31:0] dev_wdata_q, dev_wdata_d;
   logic [31:0] cycle_q, cycle_d;
   logic [15:0] wait_q, wait_d;
   logic        timeout_q, timeout_d;
   logic        collision_q, collision_d;
   logic [1:0]  w1c;
   logic        set_timeout, set_collision;
   logic        is_ext;

   assign is_ext = (IOaddr[31:8] == 24'd0);

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      state_d       = state_q;
      in_data_d     = in_data_q;
      leds_d        = leds_q;
      dev_we_d      = dev_we_q;
      dev_addr_d    = dev_addr_q;
      dev_wdata_d   = dev_wdata_q;
      cycle_d       = cycle_q + 32'd1;
      wait_d        = wait_q;
      w1c           = 2'b00;
      set_timeout   = 1'b0;
      set_collision = 1'b0;

      unique case (state_q)
         IDLE: begin
            // Simultaneous strobes: the write proceeds, the read is dropped.
            set_collision = InStrobe & OutStrobe;
            if (InStrobe | OutStrobe) begin
               if (is_ext) begin
                  dev_we_d    = OutStrobe;
                  dev_addr_d  = IOaddr[7:0];
                  dev_wdata_d = OutData;
                  wait_d      = 16'd0;
                  state_d     = DEV;
               end else if (OutStrobe) begin
                  unique case (IOaddr)
                     ADDR_LED:    leds_d  = OutData[7:0];
                     ADDR_CYCLE:  cycle_d = 32'd0;
                     ADDR_STATUS: w1c     = OutData[1:0];
                     default:     ;
                  endcase
               end else begin
                  unique case (IOaddr)
                     ADDR_LED:    in_data_d = {24'd0, leds_q};
                     ADDR_CYCLE:  in_data_d = cycle_q;
                     ADDR_STATUS: in_data_d = {30'd0, collision_q, timeout_q};
                     default:     in_data_d = 32'd0;
                  endcase
               end
            end
         end

         DEV: begin
            set_collision = InStrobe | OutStrobe;
            if (dev_ack) begin
               if (!dev_we_q) in_data_d = dev_rdata;
               state_d = IDLE;
            end else if (wait_q == WAIT_LAST) begin
               if (!dev_we_q) in_data_d = ERR_DATA;
               set_timeout = 1'b1;
               state_d     = IDLE;
            end else begin
               wait_d = wait_q + 16'd1;
            end
         end

         default: state_d = IDLE;
      endcase

      // A flag being set in the same cycle as its clear stays set.
      timeout_d   = (timeout_q & ~w1c[0]) | set_timeout;
      collision_d = (collision_q & ~w1c[1]) | set_collision;
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (Reset) begin
         state_q     <= IDLE;
         in_data_q   <= 32'd0;
         leds_q      <= 8'd0;
         dev_we_q    <= 1'b0;
         dev_addr_q  <= 8'd0;
         dev_wdata_q <= 32'd0;
         cycle_q     <= 32'd0;
         wait_q      <= 16'd0;
         timeout_q   <= 1'b0;
         collision_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         in_data_q   <= in_data_d;
         leds_q      <= leds_d;
         dev_we_q    <= dev_we_d;
         dev_addr_q  <= dev_addr_d;
         dev_wdata_q <= dev_wdata_d;
         cycle_q     <= cycle_d;
         wait_q      <= wait_d;
         timeout_q   <= timeout_d;
         collision_q <= collision_d;
      end
   end

   assign InData    = in_data_q;
   assign InRdy     = (state_q == IDLE);
   assign dev_req   = (state_q == DEV);
   assign leds      = leds_q;
   assign dev_we    = dev_we_q;
   assign dev_addr  = dev_addr_q;
   assign dev_wdata = dev_wdata_q;

endmodule

// File: tb/tb_tinycomp_io_ctrl.sv
// Bench for tinycomp_io_ctrl: transaction-level model updated per edge, every
// output compared each cycle, plus directed scenarios with literal expectations.
module tb_tinycomp_io_ctrl;

   localparam int unsigned TMO   = 8;
   localparam logic [31:0] ERR   = 32'hFFFF_FFFF;
   localparam logic [31:0] A_LED = 32'h0000_03FF;
   localparam logic [31:0] A_CYC = 32'h0000_03FE;
   localparam logic [31:0] A_STA = 32'h0000_03FD;

   logic        clk = 1'b0;
   logic        Reset;
   logic [31:0] IOaddr, OutData, InData, dev_wdata, dev_rdata;
   logic        InStrobe, OutStrobe, InRdy, dev_req, dev_we, dev_ack;
   logic [7:0]  leds, dev_addr;

   always #5 clk = ~clk;

   tinycomp_io_ctrl #(.TIMEOUT(TMO), .ERR_DATA(ERR)) dut (
      .clk(clk), .Reset(Reset), .IOaddr(IOaddr), .OutData(OutData),
      .InStrobe(InStrobe), .OutStrobe(OutStrobe), .InData(InData), .InRdy(InRdy),
      .leds(leds), .dev_req(dev_req), .dev_we(dev_we), .dev_addr(dev_addr),
      .dev_wdata(dev_wdata), .dev_rdata(dev_rdata), .dev_ack(dev_ack)
   );

   // Model state: what the CPU and device should observe.
   bit          m_busy;
   int          m_age;
   bit          m_we, m_to, m_col;
   logic [7:0]  m_addr, m_leds;
   logic [31:0] m_wdata, m_indata, m_cycle;

   int n_cmp = 0;
   int n_bad = 0;
   int req_cycles;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
      end
   endtask

   task automatic model_step(input bit rst, input bit ins, input bit outs, input logic [31:0] addr,
                             input logic [31:0] wdata, input bit ack, input logic [31:0] rdata);
      logic [31:0] next_cycle;
      bit clr_to, clr_col, set_to, set_col;
      if (rst) begin
         m_busy = 0; m_age = 0; m_we = 0; m_to = 0; m_col = 0;
         m_addr = '0; m_leds = '0; m_wdata = '0; m_indata = '0; m_cycle = '0;
         return;
      end
      next_cycle = m_cycle + 32'd1;
      clr_to = 0; clr_col = 0; set_to = 0; set_col = 0;
      if (!m_busy) begin
         set_col = ins && outs;
         if (ins || outs) begin
            if (addr < 32'd256) begin
               m_busy = 1; m_age = 0; m_we = outs; m_addr = addr[7:0]; m_wdata = wdata;
            end else if (outs) begin
               if (addr == A_LED) m_leds = wdata[7:0];
               if (addr == A_CYC) next_cycle = 32'd0;
               if (addr == A_STA) begin clr_to = wdata[0]; clr_col = wdata[1]; end
            end else begin
               if (addr == A_LED)      m_indata = {24'd0, m_leds};
               else if (addr == A_CYC) m_indata = m_cycle;
               else if (addr == A_STA) m_indata = {30'd0, m_col, m_to};
               else                    m_indata = 32'd0;
            end
         end
      end else begin
         set_col = ins || outs;
         m_age++;  // cycles dev_req has been high so far
         if (ack) begin
            m_busy = 0;
            if (!m_we) m_indata = rdata;
         end else if (m_age == int'(TMO)) begin
            m_busy = 0;
            set_to = 1;
            if (!m_we) m_indata = ERR;
         end
      end
      m_to    = (m_to && !clr_to) || set_to;
      m_col   = (m_col && !clr_col) || set_col;
      m_cycle = next_cycle;
   endtask

   task automatic compare_all();
      check("InData",    InData,         m_indata);
      check("InRdy",     32'(InRdy),     32'(!m_busy));
      check("dev_req",   32'(dev_req),   32'(m_busy));
      check("leds",      32'(leds),      32'(m_leds));
      check("dev_we",    32'(dev_we),    32'(m_we));
      check("dev_addr",  32'(dev_addr),  32'(m_addr));
      check("dev_wdata", dev_wdata,      m_wdata);
   endtask

   // One clock: drive at negedge, model at posedge, compare at next negedge.
   task automatic cycle(input bit rst, input bit ins, input bit outs, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit ack, input logic [31:0] rdata);
      Reset = rst; InStrobe = ins; OutStrobe = outs; IOaddr = addr;
      OutData = wdata; dev_ack = ack; dev_rdata = rdata;
      @(posedge clk);
      model_step(rst, ins, outs, addr, wdata, ack, rdata);
      @(negedge clk);
      compare_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, 0, 32'h0, 32'h0, 0, $urandom);
   endtask
   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      cycle(0, 0, 1, a, d, 0, 32'h0);
   endtask
   task automatic rd(input logic [31:0] a);
      cycle(0, 1, 0, a, 32'h0, 0, 32'h0);
   endtask

   initial begin
      Reset = 1; InStrobe = 0; OutStrobe = 0; IOaddr = '0; OutData = '0;
      dev_ack = 0; dev_rdata = '0;
      @(negedge clk);
      cycle(1, 0, 0, 32'h0, 32'h0, 0, 32'h0);
      cycle(1, 0, 0, 32'h0, 32'h0, 0, 32'h0);
      check("reset InData", InData, 32'h0);
      check("reset InRdy", 32'(InRdy), 32'h1);
      check("reset dev_req", 32'(dev_req), 32'h0);

      // LED write then readback, zero wait.
      wr(A_LED, 32'h1234_56A5);
      check("led write", 32'(leds), 32'hA5);
      check("led write InRdy", 32'(InRdy), 32'h1);
      rd(A_LED);
      check("led read", InData, 32'h0000_00A5);
      check("led read InRdy", 32'(InRdy), 32'h1);

      // Cycle counter clear, then read after 10 idle cycles.
      wr(A_CYC, 32'h0);
      idle(10);
      rd(A_CYC);
      check("cycle after clear", InData, 32'd10);

      // Preload near wrap.
      force dut.cycle_q = 32'hFFFF_FFFE;
      #1;
      release dut.cycle_q;
      m_cycle = 32'hFFFF_FFFE;
      idle(1);
      rd(A_CYC);
      check("cycle pre-wrap", InData, 32'hFFFF_FFFF);
      rd(A_CYC);
      check("cycle wrapped", InData, 32'h0);

      // External read, ack on the third request cycle.
      rd(32'h42);
      check("ext rd addr", 32'(dev_addr), 32'h42);
      check("ext rd we", 32'(dev_we), 32'h0);
      check("ext rd wait1", 32'(InRdy), 32'h0);
      idle(1);
      check("ext rd wait2", 32'(InRdy), 32'h0);
      idle(1);
      check("ext rd wait3", 32'(InRdy), 32'h0);
      cycle(0, 0, 0, 32'h0, 32'h0, 1, 32'hCAFE_F00D);
      check("ext rd data", InData, 32'hCAFE_F00D);
      check("ext rd done", 32'(InRdy), 32'h1);

      // External write with no ack times out after exactly TMO request cycles.
      wr(32'h10, 32'hDEAD_BEEF);
      check("ext wr we", 32'(dev_we), 32'h1);
      check("ext wr data", dev_wdata, 32'hDEAD_BEEF);
      req_cycles = 0;
      for (int i = 0; i < 20 && dev_req; i++) begin
         req_cycles++;
         idle(1);
      end
      check("timeout req cycles", req_cycles, 32'd8);
      rd(A_STA);
      check("status timeout", InData, 32'h1);
      wr(A_STA, 32'h1);
      rd(A_STA);
      check("status cleared", InData, 32'h0);

      // Collision during an access; the access still completes.
      rd(32'h20);
      wr(A_LED, 32'h77);
      check("collision leds kept", 32'(leds), 32'hA5);
      cycle(0, 0, 0, 32'h0, 32'h0, 1, 32'h1234_5678);
      check("collision access done", InData, 32'h1234_5678);
      rd(A_STA);
      check("status collision", InData, 32'h2);
      cycle(0, 1, 1, A_STA, 32'h3, 0, 32'h0);   // clear and set together
      rd(A_STA);
      check("status set wins", InData, 32'h2);
      wr(A_STA, 32'h3);
      rd(A_STA);
      check("status w1c", InData, 32'h0);

      // Reset in the middle of an access, then a stray ack.
      rd(32'h33);
      idle(1);
      cycle(1, 0, 0, 32'h0, 32'h0, 0, 32'h0);
      check("reset mid dev_req", 32'(dev_req), 32'h0);
      check("reset mid InRdy", 32'(InRdy), 32'h1);
      rd(A_STA);
      check("reset mid status", InData, 32'h0);
      cycle(0, 0, 0, 32'h0, 32'h0, 1, 32'hBAD0_BAD0);
      check("late ack ignored", InData, 32'h0);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] a, d;
         bit ins, outs, ack, rst;
         case ($urandom_range(0, 5))
            0:       a = A_LED;
            1:       a = A_CYC;
            2:       a = A_STA;
            3, 4:    a = 32'($urandom_range(0, 255));
            default: a = 32'h0000_0400 + 32'($urandom_range(0, 4000));
         endcase
         d    = (a == A_STA) ? 32'($urandom_range(0, 3)) : $urandom;
         ins  = ($urandom_range(0, 3) == 0);
         outs = ($urandom_range(0, 3) == 0);
         ack  = ($urandom_range(0, 4) == 0);
         rst  = ($urandom_range(0, 127) == 0);
         cycle(rst, ins, outs, a, d, ack, $urandom);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
